// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and constants for the load-use hazard scoreboard
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALLED = 2'd1,
        ST_TIMEOUT = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         MAX_LD_OUTSTANDING = 2;

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// rtl/hazard_scoreboard_sat_counter.sv - up/down counter clamped to [0, MAX]
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic [1:0]   dec_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;
    logic [W+1:0] sum_inc;
    logic [W+1:0] dec_ext;
    logic [W+1:0] diff;

    // Two guard bits let the sum overshoot MAX before clamping.
    always_comb begin
        sum_inc = {2'b00, count_q} + {{(W+1){1'b0}}, inc_i};
        dec_ext = {{W{1'b0}}, dec_i};
        diff    = sum_inc - dec_ext;
        count_d = count_q;
        if (sum_inc < dec_ext) begin
            count_d = '0;
        end else if (diff > {2'b00, MAX}) begin
            count_d = MAX;
        end else begin
            count_d = diff[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-load scoreboard driving ID stall/bubble with a stall watchdog
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_is_load,
    input  logic             ld_done,
    input  logic [4:0]       ld_done_rd,
    input  logic             ex_flush,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    output logic             stall,
    output logic             bubble,
    output logic [NREGS-1:0] load_pend,
    output logic [1:0]       ld_outstanding,
    output logic [15:0]      stall_count,
    output logic             hazard_timeout
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [NREGS-1:0] load_pend_q, load_pend_d;
    logic [31:0]      pend_ext;
    logic             issue, ld_issue, flush_ld;
    logic [1:0]       ld_dec;
    logic             rs1_hit, rs2_hit, ld_full;

    hz_state_e        state_q;
    logic [7:0]       stall_run_q;
    logic             hazard_timeout_q;

    assign pend_ext = 32'(load_pend_q);
    assign rs1_hit  = id_uses_rs1 && pend_ext[id_rs1] && (id_rs1 != REG_ZERO);
    assign rs2_hit  = id_uses_rs2 && pend_ext[id_rs2] && (id_rs2 != REG_ZERO);
    assign ld_full  = id_is_load && (ld_outstanding == 2'(MAX_LD_OUTSTANDING));

    // Depends only on registered state, so a same-cycle ld_done cannot release it.
    assign stall    = id_valid && (rs1_hit || rs2_hit || ld_full);
    assign bubble   = stall;

    assign issue    = id_valid && !stall;
    assign ld_issue = issue && id_is_load;
    assign flush_ld = ex_flush && ex_is_load;
    assign ld_dec   = {1'b0, ld_done} + {1'b0, flush_ld};

    assign load_pend_d[0] = 1'b0;
    for (genvar g = 1; g < NREGS; g++) begin : g_pend
        logic set_b, clr_b;
        assign set_b = ld_issue && (id_rd == 5'(g));
        assign clr_b = (ld_done && (ld_done_rd == 5'(g))) || (flush_ld && (ex_rd == 5'(g)));
        assign load_pend_d[g] = set_b || (load_pend_q[g] && !clr_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_pend_q <= '0;
        end else begin
            load_pend_q <= load_pend_d;
        end
    end

    sat_counter #(
        .W   (2),
        .MAX (2'(MAX_LD_OUTSTANDING))
    ) u_ld_outstanding (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (ld_issue),
        .dec_i   (ld_dec),
        .count_o (ld_outstanding)
    );

    sat_counter #(
        .W   (16),
        .MAX (16'hFFFF)
    ) u_stall_count (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall),
        .dec_i   (2'b00),
        .count_o (stall_count)
    );

    // The run counter includes the cycle that entered STALLED, so TIMEOUT
    // consecutive stall cycles land exactly on the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            stall_run_q      <= 8'd0;
            hazard_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stall) begin
                        stall_run_q <= 8'd1;
                        if (TIMEOUT_CNT <= 8'd1) begin
                            state_q          <= ST_TIMEOUT;
                            hazard_timeout_q <= 1'b1;
                        end else begin
                            state_q <= ST_STALLED;
                        end
                    end else begin
                        stall_run_q <= 8'd0;
                    end
                end
                ST_STALLED: begin
                    if (!stall) begin
                        state_q     <= ST_IDLE;
                        stall_run_q <= 8'd0;
                    end else begin
                        stall_run_q <= stall_run_q + 8'd1;
                        if ((stall_run_q + 8'd1) >= TIMEOUT_CNT) begin
                            state_q          <= ST_TIMEOUT;
                            hazard_timeout_q <= 1'b1;
                        end
                    end
                end
                ST_TIMEOUT: begin
                    hazard_timeout_q <= 1'b1;
                end
                default: begin
                    state_q          <= ST_IDLE;
                    stall_run_q      <= 8'd0;
                    hazard_timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign load_pend      = load_pend_q;
    assign hazard_timeout = hazard_timeout_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_is_load;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ld_done, ex_flush, ex_is_load;
    logic [4:0]  ld_done_rd, ex_rd;
    logic        stall, bubble, hazard_timeout;
    logic [31:0] load_pend;
    logic [1:0]  ld_outstanding;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(.NREGS(32), .TIMEOUT(255)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rd          (id_rd),
        .id_is_load     (id_is_load),
        .ld_done        (ld_done),
        .ld_done_rd     (ld_done_rd),
        .ex_flush       (ex_flush),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .stall          (stall),
        .bubble         (bubble),
        .load_pend      (load_pend),
        .ld_outstanding (ld_outstanding),
        .stall_count    (stall_count),
        .hazard_timeout (hazard_timeout)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_load = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        ld_done = 0; ld_done_rd = 0; ex_flush = 0; ex_is_load = 0; ex_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue_load(input logic [4:0] rd);
        drive_idle();
        id_valid = 1; id_is_load = 1; id_rd = rd;
    endtask

    task automatic read_regs(input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2);
        drive_idle();
        id_valid = 1; id_uses_rs1 = u1; id_rs1 = r1; id_uses_rs2 = u2; id_rs2 = r2;
    endtask

    task automatic test_reset();
        drive_idle();
        #2;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got %b want 0", stall); end
        total++; if (load_pend !== 32'h0) begin bad++; $display("FAIL rst_load_pend got %h want 0", load_pend); end
        total++; if (ld_outstanding !== 2'd0) begin bad++; $display("FAIL rst_outstanding got %0d want 0", ld_outstanding); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL rst_stall_count got %0d want 0", stall_count); end
        total++; if (hazard_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got %b want 0", hazard_timeout); end
        tick();
        rst = 1'b0;
        issue_load(5'd2);
        tick();
        drive_idle();
        total++; if (load_pend !== 32'h4) begin bad++; $display("FAIL first_issue_pend got %h want 00000004", load_pend); end
        total++; if (ld_outstanding !== 2'd1) begin bad++; $display("FAIL first_issue_outstanding got %0d want 1", ld_outstanding); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue_load(5'd5);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_issue_stall got %b want 0", stall); end
        tick();
        read_regs(1'b1, 5'd5, 1'b0, 5'd0);
        ld_done = 1; ld_done_rd = 5'd5;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got %b want 1", stall); end
        total++; if (bubble !== 1'b1) begin bad++; $display("FAIL lu_bubble got %b want 1", bubble); end
        tick();
        ld_done = 0; ld_done_rd = 0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release got %b want 0", stall); end
        total++; if (bubble !== 1'b0) begin bad++; $display("FAIL lu_bubble_release got %b want 0", bubble); end
        total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL lu_stall_count got %0d want 1", stall_count); end
        total++; if (load_pend !== 32'h0) begin bad++; $display("FAIL lu_pend got %h want 0", load_pend); end
        tick();
        drive_idle();
    endtask

    task automatic test_x0_unused();
        do_reset();
        issue_load(5'd0);
        tick();
        read_regs(1'b1, 5'd0, 1'b1, 5'd0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall got %b want 0", stall); end
        total++; if (load_pend !== 32'h0) begin bad++; $display("FAIL x0_pend got %h want 0", load_pend); end
        tick();
        do_reset();
        issue_load(5'd7);
        tick();
        read_regs(1'b1, 5'd1, 1'b0, 5'd7);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL unused_rs2_stall got %b want 0", stall); end
        total++; if (load_pend !== 32'h80) begin bad++; $display("FAIL unused_pend got %h want 00000080", load_pend); end
        tick();
        drive_idle();
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL unused_stall_count got %0d want 0", stall_count); end
    endtask

    task automatic test_flush();
        do_reset();
        issue_load(5'd9);
        tick();
        drive_idle();
        ex_flush = 1; ex_is_load = 1; ex_rd = 5'd9;
        tick();
        drive_idle();
        total++; if (load_pend[9] !== 1'b0) begin bad++; $display("FAIL flush_pend9 got %b want 0", load_pend[9]); end
        total++; if (ld_outstanding !== 2'd0) begin bad++; $display("FAIL flush_outstanding got %0d want 0", ld_outstanding); end
        read_regs(1'b1, 5'd9, 1'b0, 5'd0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_reader_stall got %b want 0", stall); end
        tick();
        drive_idle();
    endtask

    task automatic test_outstanding();
        do_reset();
        issue_load(5'd3);
        tick();
        issue_load(5'd4);
        tick();
        total++; if (ld_outstanding !== 2'd2) begin bad++; $display("FAIL out_two got %0d want 2", ld_outstanding); end
        issue_load(5'd10);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL out_third_stall got %b want 1", stall); end
        tick();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL out_still_stall got %b want 1", stall); end
        total++; if (ld_outstanding !== 2'd2) begin bad++; $display("FAIL out_capped got %0d want 2", ld_outstanding); end
        ld_done = 1; ld_done_rd = 5'd3;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL out_done_same_cycle got %b want 1", stall); end
        tick();
        ld_done = 0; ld_done_rd = 0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL out_release got %b want 0", stall); end
        total++; if (ld_outstanding !== 2'd1) begin bad++; $display("FAIL out_after_done got %0d want 1", ld_outstanding); end
        tick();
        drive_idle();
        total++; if (ld_outstanding !== 2'd2) begin bad++; $display("FAIL out_after_issue got %0d want 2", ld_outstanding); end
        total++; if (load_pend !== 32'h410) begin bad++; $display("FAIL out_pend got %h want 00000410", load_pend); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        issue_load(5'd6);
        tick();
        issue_load(5'd6);
        ld_done = 1; ld_done_rd = 5'd6;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL simul_stall got %b want 0", stall); end
        tick();
        drive_idle();
        total++; if (load_pend[6] !== 1'b1) begin bad++; $display("FAIL simul_pend6 got %b want 1", load_pend[6]); end
        total++; if (ld_outstanding !== 2'd1) begin bad++; $display("FAIL simul_outstanding got %0d want 1", ld_outstanding); end
    endtask

    task automatic test_timeout();
        do_reset();
        issue_load(5'd5);
        tick();
        read_regs(1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL to_stall_start got %b want 1", stall); end
        repeat (254) tick();
        total++; if (hazard_timeout !== 1'b0) begin bad++; $display("FAIL to_early got %b want 0", hazard_timeout); end
        total++; if (stall_count !== 16'd254) begin bad++; $display("FAIL to_count254 got %0d want 254", stall_count); end
        tick();
        total++; if (hazard_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got %b want 1", hazard_timeout); end
        total++; if (stall_count !== 16'd255) begin bad++; $display("FAIL to_count255 got %0d want 255", stall_count); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL to_stall_kept got %b want 1", stall); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL to_rst_stall got %b want 0", stall); end
        total++; if (hazard_timeout !== 1'b0) begin bad++; $display("FAIL to_rst_flag got %b want 0", hazard_timeout); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL to_rst_count got %0d want 0", stall_count); end
        total++; if (load_pend !== 32'h0) begin bad++; $display("FAIL to_rst_pend got %h want 0", load_pend); end
        drive_idle();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_unused();
        test_flush();
        test_outstanding();
        test_simultaneous();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
- REQ-001 SHALL have parameter NREGS, default 32, meaning the number of architectural registers tracked; register x0 is never tracked.
- REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the number of consecutive stall cycles before a timeout is flagged.
- REQ-003 SHALL use one clock, `clk`; reset `rst` SHALL be asynchronous and active-high.
- REQ-004 SHALL have these decode-stage inputs, all 1 bit unless noted:
  - id_valid: ID holds a valid instruction.
  - id_rs1 [4:0], id_rs2 [4:0]: source register numbers.
  - id_uses_rs1, id_uses_rs2: the instruction reads rs1 / rs2.
  - id_rd [4:0]: destination register number.
  - id_is_load: the instruction is a load.
- REQ-005 SHALL have these memory and control inputs:
  - ld_done: load data is now in MEM/WB and can be forwarded.
  - ld_done_rd [4:0]: destination register of the completing load.
  - ex_flush: kill the instruction in EX.
  - ex_is_load: the instruction in EX is a load.
  - ex_rd [4:0]: destination register of the instruction in EX.
- REQ-006 SHALL have these outputs:
  - stall: hold PC and IF/ID.
  - bubble: insert a NOP into ID/EX.
  - load_pend [NREGS-1:0]: pending-load bitmap.
  - ld_outstanding [1:0]: number of in-flight loads.
  - stall_count [15:0]: performance counter of stall cycles.
  - hazard_timeout: sticky error flag.

Function
- REQ-007 `issue` SHALL be defined as id_valid & ~stall.
- REQ-008 On a cycle where issue & id_is_load & id_rd!=0, load_pend[id_rd] SHALL be set at the next edge.
- REQ-009 On a cycle where ld_done & ld_done_rd!=0, load_pend[ld_done_rd] SHALL be cleared at the next edge.
- REQ-010 On a cycle where ex_flush & ex_is_load & ex_rd!=0, load_pend[ex_rd] SHALL be cleared at the next edge.
- REQ-011 If a set and a clear target the same register in the same cycle, the set SHALL win.
- REQ-012 ld_outstanding SHALL increment on each load issue.
- REQ-013 ld_outstanding SHALL decrement on ld_done and on a flushed EX load, each event counting once.
- REQ-014 ld_outstanding SHALL saturate at 0 and 2; increments and decrements in the same cycle SHALL net out.
- REQ-015 stall SHALL be combinational and asserted when id_valid and any of the following holds:
  - id_uses_rs1 & load_pend[id_rs1] & id_rs1!=0
  - id_uses_rs2 & load_pend[id_rs2] & id_rs2!=0
  - id_is_load & ld_outstanding==2
- REQ-016 A ld_done for the register being read in the same cycle SHALL NOT release the stall in that cycle; stall SHALL release the following cycle.
- REQ-017 bubble SHALL equal stall.
- REQ-018 ex_flush SHALL NOT force stall.
- REQ-019 stall_count SHALL increment each cycle stall=1 and SHALL saturate at 16'hFFFF.
- REQ-020 The FSM SHALL have states IDLE, STALLED and TIMEOUT, with these transitions:
  - IDLE->STALLED when stall=1.
  - STALLED->IDLE when stall=0.
  - STALLED->TIMEOUT when the consecutive-stall counter reaches TIMEOUT.
  - TIMEOUT is terminal until reset.
- REQ-021 The consecutive-stall counter SHALL be 8 bits, SHALL clear on entry to IDLE, and SHALL increment while in STALLED.
- REQ-022 hazard_timeout SHALL be 1 only in TIMEOUT.
- REQ-023 Entering TIMEOUT SHALL NOT alter stall, which remains purely combinational.
- REQ-024 Scoreboard state updates SHALL continue in every FSM state.

Reset
- REQ-025 On rst SHALL clear load_pend, ld_outstanding, stall_count and the consecutive-stall counter, set the FSM to IDLE, and drive hazard_timeout=0.
- REQ-026 Reset asserted mid-stall SHALL drop stall in the same cycle, since load_pend clears asynchronously.
- REQ-027 The first issue SHALL be accepted on the first edge after rst deasserts.

Structure
- REQ-028 Shared package SHALL hold: FSM state encoding (IDLE=2'd0, STALLED=2'd1, TIMEOUT=2'd2), REG_ZERO=5'd0, MAX_LD_OUTSTANDING=2.
- REQ-029 A single sub-module `sat_counter`, parameterized by width and with inc/dec/saturate behaviour, SHALL be used for both ld_outstanding and stall_count.
- REQ-030 The per-register set/clear logic SHALL be generated inline; no further sub-modules.

Verification
- REQ-031 Load-use hazard:
  - Stimulus: issue load x5, then next ID reads x5 with uses_rs1=1; ld_done rd=5 after 1 cycle.
  - Required response: stall=bubble=1 for exactly 1 cycle, stall_count=1.
- REQ-032 x0 and unused sources:
  - Stimulus: load with rd=0, then a read of x0; separately, load x7, then a read of x7 with uses_rs2=0.
  - Required response: stall=0 throughout, load_pend=0 for the x0 case.
- REQ-033 Flush:
  - Stimulus: issue load x9, ex_flush with ex_is_load=1, ex_rd=9.
  - Required response: load_pend[9]=0, ld_outstanding=0; next reader of x9 does not stall.
- REQ-034 Outstanding limit:
  - Stimulus: two loads outstanding (x3, x4), then a third load.
  - Required response: stall=1 until one ld_done, then issue; ld_outstanding never exceeds 2.
- REQ-035 Simultaneous set/clear:
  - Stimulus: issue load x6 in the same cycle ld_done rd=6 arrives.
  - Required response: load_pend[6]=1 afterwards, ld_outstanding unchanged.
- REQ-036 Timeout and reset:
  - Stimulus: hold a dependent read with no ld_done for 255 cycles, then pulse rst mid-stall.
  - Required response: hazard_timeout=1 at cycle 255; rst gives stall=0, hazard_timeout=0, stall_count=0.
